// File: rtl/vx_data_sched_pkg.sv
// ============================================================================
// Module  : vx_data_sched_pkg
// Brief   : Shared types and width helpers for the cache-bank data scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vx_data_sched_pkg;

    typedef enum logic [0:0] {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int f_line_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int f_wsel_bits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int CFG_LINES          = 64;
    localparam int CFG_WORDS_PER_LINE = 4;
    localparam int CFG_WORD_SIZE      = 4;
    localparam int CFG_NUM_PORTS      = 1;
    localparam int CFG_TAG_WIDTH      = 8;
    localparam int CFG_LINE_BITS      = f_line_bits(CFG_LINES);
    localparam int CFG_WSEL_BITS      = f_wsel_bits(CFG_WORDS_PER_LINE);
    localparam int CFG_WORD_W         = 8 * CFG_WORD_SIZE;

    typedef struct packed {
        logic                                     rw;
        logic [CFG_LINE_BITS-1:0]                 addr;
        logic [CFG_NUM_PORTS*CFG_WSEL_BITS-1:0]   wsel;
        logic [CFG_NUM_PORTS-1:0]                 pmask;
        logic [CFG_NUM_PORTS*CFG_WORD_SIZE-1:0]   byteen;
        logic [CFG_NUM_PORTS*CFG_WORD_W-1:0]      data;
        logic [CFG_TAG_WIDTH-1:0]                 tag;
    } core_req_t;

endpackage

`default_nettype wire

// File: rtl/vx_data_sched_rsp.sv
// ============================================================================
// Module  : vx_data_sched_rsp
// Brief   : Read-tag stage, response register and store stall generation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vx_data_sched_rsp #(
    parameter int TAG_WIDTH = 8,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_s0_read,
    input  logic [TAG_WIDTH-1:0] i_s0_tag,
    input  logic [DATA_W-1:0]    i_read_data,
    input  logic                 i_rsp_ready,
    output logic                 o_s1_valid,
    output logic                 o_stall,
    output logic                 o_rsp_valid,
    output logic [DATA_W-1:0]    o_rsp_data,
    output logic [TAG_WIDTH-1:0] o_rsp_tag
);

    logic                 r_s1_valid;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic                 r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;
    logic [TAG_WIDTH-1:0] r_rsp_tag;
    logic                 w_stall;

    // An unconsumed response freezes both this stage and the store's output.
    assign w_stall = r_rsp_valid & ~i_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_tag    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= i_s0_read;
            r_s1_tag   <= i_s0_tag;
            if (r_s1_valid) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= i_read_data;
                r_rsp_tag   <= r_s1_tag;
            end else begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_s1_valid  = r_s1_valid;
    assign o_stall     = w_stall;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_tag   = r_rsp_tag;

endmodule

`default_nettype wire

// File: rtl/vx_data_sched.sv
// ============================================================================
// Module  : vx_data_sched
// Brief   : Fill/core arbiter, zeroing sweep and read return for one bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vx_data_sched
    import vx_data_sched_pkg::*;
#(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_SIZE      = 4,
    parameter int NUM_PORTS      = 1,
    parameter int TAG_WIDTH      = 8,
    parameter int STARVE_LIMIT   = 4,
    localparam int LINE_BITS     = f_line_bits(LINES),
    localparam int WSEL_BITS     = f_wsel_bits(WORDS_PER_LINE),
    localparam int WORD_W        = 8 * WORD_SIZE
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_flush_start,
    output logic                                o_flush_busy,
    input  logic                                i_fill_valid,
    input  logic [LINE_BITS-1:0]                i_fill_addr,
    input  logic [WORDS_PER_LINE*WORD_W-1:0]    i_fill_data,
    output logic                                o_fill_ready,
    input  logic                                i_core_req_valid,
    input  logic                                i_core_req_rw,
    input  logic [LINE_BITS-1:0]                i_core_req_addr,
    input  logic [NUM_PORTS*WSEL_BITS-1:0]      i_core_req_wsel,
    input  logic [NUM_PORTS-1:0]                i_core_req_pmask,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]      i_core_req_byteen,
    input  logic [NUM_PORTS*WORD_W-1:0]         i_core_req_data,
    input  logic [TAG_WIDTH-1:0]                i_core_req_tag,
    output logic                                o_core_req_ready,
    output logic                                o_core_rsp_valid,
    output logic [NUM_PORTS*WORD_W-1:0]         o_core_rsp_data,
    output logic [TAG_WIDTH-1:0]                o_core_rsp_tag,
    input  logic                                i_core_rsp_ready,
    output logic                                o_da_stall,
    output logic                                o_da_read,
    output logic                                o_da_fill,
    output logic                                o_da_write,
    output logic [LINE_BITS-1:0]                o_da_addr,
    output logic [NUM_PORTS*WSEL_BITS-1:0]      o_da_wsel,
    output logic [NUM_PORTS-1:0]                o_da_pmask,
    output logic [NUM_PORTS*WORD_SIZE-1:0]      o_da_byteen,
    output logic [WORDS_PER_LINE*WORD_W-1:0]    o_da_fill_data,
    output logic [NUM_PORTS*WORD_W-1:0]         o_da_write_data,
    input  logic [NUM_PORTS*WORD_W-1:0]         i_da_read_data
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [LINE_BITS-1:0] r_line_cnt;
    logic [STV_W-1:0]     r_starve_cnt;
    logic                 r_pend_flush;
    core_req_t            w_req;
    logic                 w_run, w_sweep, w_open, w_force_core;
    logic                 w_fill_acc, w_core_acc, w_flush_go;
    logic                 w_stall, w_s1_valid, w_rsp_valid;

    assign w_req.rw     = i_core_req_rw;
    assign w_req.addr   = i_core_req_addr;
    assign w_req.wsel   = i_core_req_wsel;
    assign w_req.pmask  = i_core_req_pmask;
    assign w_req.byteen = i_core_req_byteen;
    assign w_req.data   = i_core_req_data;
    assign w_req.tag    = i_core_req_tag;

    // Reset masks issue combinationally so the store sees idle controls while held.
    assign w_run        = (r_state == ST_RUN) & ~reset;
    assign w_sweep      = (r_state == ST_FLUSH) & ~reset;
    assign w_force_core = (r_starve_cnt == STV_W'(STARVE_LIMIT)) & i_core_req_valid;
    assign w_open       = w_run & ~w_stall & ~r_pend_flush;
    assign o_fill_ready     = w_open & ~w_force_core;
    assign o_core_req_ready = w_open & (~i_fill_valid | w_force_core);
    assign w_fill_acc   = i_fill_valid & o_fill_ready;
    assign w_core_acc   = i_core_req_valid & o_core_req_ready;
    assign w_flush_go   = r_pend_flush & ~w_s1_valid & ~w_rsp_valid;
    assign o_flush_busy = (r_state == ST_FLUSH) | reset;
    assign o_da_stall   = w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FLUSH;
            r_line_cnt   <= '0;
            r_starve_cnt <= '0;
            r_pend_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FLUSH) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
            if (w_flush_go) begin
                r_pend_flush <= 1'b0;
            end else if ((r_state == ST_RUN) && i_flush_start) begin
                r_pend_flush <= 1'b1;
            end
            if (w_core_acc) begin
                r_starve_cnt <= '0;
            end else if (w_fill_acc && i_core_req_valid) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        o_da_fill       = 1'b0;
        o_da_read       = 1'b0;
        o_da_write      = 1'b0;
        o_da_addr       = '0;
        o_da_wsel       = '0;
        o_da_pmask      = '0;
        o_da_byteen     = '0;
        o_da_fill_data  = '0;
        o_da_write_data = '0;
        case (r_state)
            ST_FLUSH: if (r_line_cnt == LINE_BITS'(LINES - 1)) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_flush_go) w_state_nxt = ST_FLUSH;
            default:  w_state_nxt = ST_FLUSH;
        endcase
        if (w_sweep) begin
            o_da_fill = 1'b1;
            o_da_addr = r_line_cnt;
        end else if (w_fill_acc) begin
            o_da_fill      = 1'b1;
            o_da_addr      = i_fill_addr;
            o_da_fill_data = i_fill_data;
        end else if (w_core_acc) begin
            o_da_read       = ~w_req.rw;
            o_da_write      = w_req.rw;
            o_da_addr       = w_req.addr;
            o_da_wsel       = w_req.wsel;
            o_da_pmask      = w_req.pmask;
            o_da_byteen     = w_req.byteen;
            o_da_write_data = w_req.data;
        end
    end

    vx_data_sched_rsp #(
        .TAG_WIDTH (TAG_WIDTH),
        .DATA_W    (NUM_PORTS * WORD_W)
    ) u_rsp (
        .clk         (clk),
        .reset       (reset),
        .i_s0_read   (w_core_acc & ~w_req.rw),
        .i_s0_tag    (w_req.tag),
        .i_read_data (i_da_read_data),
        .i_rsp_ready (i_core_rsp_ready),
        .o_s1_valid  (w_s1_valid),
        .o_stall     (w_stall),
        .o_rsp_valid (w_rsp_valid),
        .o_rsp_data  (o_core_rsp_data),
        .o_rsp_tag   (o_core_rsp_tag)
    );

    assign o_core_rsp_valid = w_rsp_valid;

endmodule

`default_nettype wire
